// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated-window frequency meter.
//   state_t          : FSM state encoding (IDLE/ARM/GATE/DONE)
//   DEF_GATE_CYCLES  : default window length, 1 s at a 40 MHz clk
package freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned DEF_GATE_CYCLES = 40_000_000;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of the frequency meter.
//   start    : level-sampled measurement request (master -> slave)
//   cont     : free-running mode select          (master -> slave)
//   busy     : measurement in progress           (slave -> master)
//   done     : one-cycle result strobe           (slave -> master)
//   count    : edges seen in last window         (slave -> master)
//   overflow : last window saturated count       (slave -> master)
interface freq_meter_if #(
   parameter int CNT_W = 20
) ();

   logic             start;
   logic             cont;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             overflow;

   modport master (
      output start, cont,
      input  busy, done, count, overflow
   );

   modport slave (
      input  start, cont,
      output busy, done, count, overflow
   );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Synchronizer plus rising-edge detector for an asynchronous input.
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset
//   sig_in : asynchronous input
//   rise   : one-cycle pulse, STAGES+1 cycles after a sig_in rising edge
module freq_meter_sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], sig_in};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency counter. Counts rising edges of sig_in over
// GATE_CYCLES clk cycles and reports the (saturating) total with a done pulse.
// Single-shot on start, or back-to-back windows while cont=1.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   sig_in : asynchronous signal under measurement
//   bus    : start/cont in, busy/done/count/overflow out
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned GATE_W      = 26,
   parameter int unsigned CNT_W       = 20,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sig_in,
   freq_meter_if.slave  bus
);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   // Saturating increment: sticks at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
      if (inc && (v != '1)) return v + CNT_W'(1);
      return v;
   endfunction

   logic rise;

   freq_meter_sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .rise   (rise)
   );

   state_t            state_q, state_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  edge_q, edge_d;
   logic              ovf_int_q, ovf_int_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   // Edge counter value including this cycle's rise; used both for the running
   // count and for the result latched on the last gate cycle.
   logic [CNT_W-1:0]  edge_next;
   logic              ovf_next;

   assign edge_next = sat_inc(edge_q, rise);
   assign ovf_next  = ovf_int_q | (rise & (edge_q == '1));

   always_comb begin
      state_d    = state_q;
      gate_d     = gate_q;
      edge_d     = edge_q;
      ovf_int_d  = ovf_int_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_ARM;
         end
         ST_ARM: begin
            gate_d    = '0;
            edge_d    = '0;
            ovf_int_d = 1'b0;
            state_d   = ST_GATE;
         end
         ST_GATE: begin
            gate_d    = gate_q + GATE_W'(1);
            edge_d    = edge_next;
            ovf_int_d = ovf_next;
            if (gate_q == GATE_LAST) begin
               // Result registers load on the same edge that enters DONE so
               // they are valid alongside the done pulse.
               count_d    = edge_next;
               overflow_d = ovf_next;
               done_d     = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = bus.cont ? ST_ARM : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gate_q     <= '0;
         edge_q     <= '0;
         ovf_int_q  <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_q     <= gate_d;
         edge_q     <= edge_d;
         ovf_int_q  <= ovf_int_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an 8-bit and a 4-bit result instance share one
// stimulus signal; expected results are queued at start and checked on done.
module tb_freq_meter;

   localparam int GC = 100;

   logic clk;
   logic rst_n;
   logic sig_in;

   freq_meter_if #(.CNT_W(8)) if8 ();
   freq_meter_if #(.CNT_W(4)) if4 ();

   freq_meter #(.GATE_CYCLES(GC), .GATE_W(26), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(if8)
   );

   freq_meter #(.GATE_CYCLES(GC), .GATE_W(26), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(if4)
   );

   typedef struct {
      int cnt;
      int ovf;
      int cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int sig_period = 0;   // 0 = hold sig_hold
   int sig_hold   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus signal: square wave of sig_period clk cycles, changing 2 time
   // units after the rising edge.
   initial begin
      int ph;
      int last_p;
      ph = 0;
      last_p = 0;
      sig_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (sig_period != last_p) begin
            ph = 0;
            last_p = sig_period;
         end
         if (sig_period == 0) begin
            sig_in = sig_hold[0];
         end else begin
            sig_in = (ph < sig_period / 2);
            ph = (ph + 1) % sig_period;
         end
      end
   end

   function automatic void check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && if8.done) begin
         if (q8.size() == 0) begin
            check("done8_unexpected", 1, 0);
         end else begin
            e = q8.pop_front();
            check("count8", if8.count, e.cnt);
            check("overflow8", if8.overflow, e.ovf);
            check("done8_cycle", cyc, e.cyc);
         end
      end
      if (rst_n && if4.done) begin
         if (q4.size() == 0) begin
            check("done4_unexpected", 1, 0);
         end else begin
            e = q4.pop_front();
            check("count4", if4.count, e.cnt);
            check("overflow4", if4.overflow, e.ovf);
            check("done4_cycle", cyc, e.cyc);
         end
      end
   end

   // Start pulse on one instance; k is the edge count at which start is sampled.
   task automatic do_start(input int which, output int k);
      @(negedge clk);
      if (which == 8) if8.start = 1'b1; else if4.start = 1'b1;
      @(negedge clk);
      k = cyc;
      if8.start = 1'b0;
      if4.start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q8.size() != 0 || q4.size() != 0) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain_pending", q8.size() + q4.size(), 0);
      q8.delete();
      q4.delete();
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      if8.start = 1'b0; if8.cont = 1'b0;
      if4.start = 1'b0; if4.cont = 1'b0;

      // 1: reset with sig_in toggling
      sig_period = 4;
      wait_cycles(10);
      check("rst_busy8", if8.busy, 0);
      check("rst_done8", if8.done, 0);
      check("rst_count8", if8.count, 0);
      check("rst_ovf8", if8.overflow, 0);
      check("rst_busy4", if4.busy, 0);
      check("rst_count4", if4.count, 0);
      check("rst_ovf4", if4.overflow, 0);
      rst_n = 1'b1;

      // 2: period 10 -> 10 edges; latency and busy
      sig_period = 10;
      wait_cycles(20);
      do_start(8, k);
      q8.push_back('{10, 0, k + GC + 1});
      check("busy_after_start", if8.busy, 1);
      wait_cycles(50);
      check("busy_mid_window", if8.busy, 1);
      check("done_mid_window", if8.done, 0);
      drain(GC + 20);
      @(negedge clk);
      check("busy_after_done", if8.busy, 0);
      wait_cycles(5);
      check("count_holds", if8.count, 10);

      // 3: held high -> 0, then period 2 -> 50
      sig_period = 0;
      sig_hold = 1;
      wait_cycles(10);
      do_start(8, k);
      q8.push_back('{0, 0, k + GC + 1});
      drain(GC + 20);
      sig_period = 2;
      wait_cycles(10);
      do_start(8, k);
      q8.push_back('{50, 0, k + GC + 1});
      drain(GC + 20);

      // 4: 4-bit counter saturates, then recovers
      wait_cycles(5);
      do_start(4, k);
      q4.push_back('{15, 1, k + GC + 1});
      drain(GC + 20);
      sig_period = 20;
      wait_cycles(25);
      do_start(4, k);
      q4.push_back('{5, 0, k + GC + 1});
      drain(GC + 20);
      wait_cycles(5);
      check("count4_holds", if4.count, 5);
      check("busy4_idle", if4.busy, 0);

      // 5: continuous mode, ignored extra start, stop after current window
      sig_period = 10;
      wait_cycles(20);
      if8.cont = 1'b1;
      do_start(8, k);
      q8.push_back('{10, 0, k + GC + 1});
      q8.push_back('{10, 0, k + 2 * GC + 3});
      q8.push_back('{10, 0, k + 3 * GC + 5});
      wait_cycles(50);
      @(negedge clk); if8.start = 1'b1;
      @(negedge clk); if8.start = 1'b0;
      wait_cycles(200);
      check("busy_cont_win2", if8.busy, 1);
      if8.cont = 1'b0;
      drain(GC + 40);
      wait_cycles(2);
      check("busy_after_cont_stop", if8.busy, 0);
      wait_cycles(150);
      check("still_idle", if8.busy, 0);

      // 6: reset mid-window, then fresh measurement
      do_start(8, k);
      wait_cycles(51);
      rst_n = 1'b0;
      wait_cycles(3);
      check("midrst_busy", if8.busy, 0);
      check("midrst_done", if8.done, 0);
      check("midrst_count", if8.count, 0);
      check("midrst_ovf", if8.overflow, 0);
      rst_n = 1'b1;
      wait_cycles(GC + 10);
      check("postrst_busy", if8.busy, 0);
      check("postrst_count", if8.count, 0);
      do_start(8, k);
      q8.push_back('{10, 0, k + GC + 1});
      drain(GC + 20);
      wait_cycles(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
